yarvi_wb: RTL
=============

Name: yarvi_wb

Overview:
- Writeback stage sitting directly downstream of the memory/load-store stage.
- Consumes that stage's me_valid, me_wb_en, me_wb_rd and me_wb_val outputs, commits results into the 32-entry integer register file and counts retired instructions.
- Provides two synchronous read ports, with write-first forwarding, to the decode/register-read stage.
- Registers the retired result for trace and debug consumers.

Parameters:
- XLEN, 32, data width of registers and results.
- BYPASS, 1, when 1 the read outputs also forward the write being performed in the current cycle; when 0 they show array contents plus registered forwarding only.
- INSTRET_W, 64, width of the retired-instruction counter.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- me_valid  in  1  an instruction retires from the memory stage this cycle.
- me_wb_en  in  1  the retiring instruction writes a register.
- me_wb_rd  in  5  destination register index.
- me_wb_val  in  XLEN  result value (load data or bypassed ALU value).
- hold  in  1  read stage stalled; freezes the read-address registers.
- rs1_addr  in  5  read port 1 address, sampled on posedge when hold=0.
- rs2_addr  in  5  read port 2 address, sampled on posedge when hold=0.
- rs1_val  out  XLEN  read port 1 data for the latched address.
- rs2_val  out  XLEN  read port 2 data for the latched address.
- wb_valid  out  1  registered copy of me_valid.
- wb_wen  out  1  registered copy of the effective write enable.
- wb_rd  out  5  registered destination index.
- wb_val  out  XLEN  registered written value.
- instret  out  INSTRET_W  count of retired instructions.

Behaviour:
- Effective write enable: we = me_valid & me_wb_en & (me_wb_rd != 0).
  - When we=1, regs[me_wb_rd] is updated with me_wb_val at posedge.
  - Writes to x0 are discarded and never set wb_wen.
- Read-address latches: ra1/ra2 load rs1_addr/rs2_addr at posedge when hold=0 and keep their value when hold=1.
- Read data is rs1_val = f(ra1), with forwarding priority highest first:
  - ra1==0 gives 0.
  - BYPASS=1 and we and me_wb_rd==ra1 gives me_wb_val (combinational).
  - Otherwise the array content.
  - The array is write-first: a write on the same edge that latches ra1 is visible the next cycle.
  - rs2_val follows the same rule with ra2.
- Read latency: an address presented in cycle N produces data valid throughout cycle N+1. While hold=1, the data tracks any later writes to the held address.
- wb_valid, wb_wen, wb_rd and wb_val are registered every cycle from me_valid, we, me_wb_rd and me_wb_val, giving 1 cycle of latency.
  - When wb_wen=0, wb_val still carries the captured value.
- instret increments by 1 on each posedge with me_valid=1, wrapping modulo 2^INSTRET_W with no saturation.
- Reset (asynchronous assert, synchronous-safe deassert by the environment):
  - ra1, ra2, wb_valid, wb_wen, wb_rd, wb_val and instret become 0 immediately.
  - rs1_val and rs2_val therefore read 0 during reset.
  - Array contents are not reset; x0 reads 0 regardless.
  - A retire coinciding with reset is dropped: no write and no count.
- me_valid=0 with me_wb_en=1 performs no write and no count.
- Simultaneous hold=1 and a write to the held address: the held data shows the new value the next cycle, or the same cycle if BYPASS=1.
- Both ports may address the same register; both return identical data.
- There is no back-pressure toward the memory stage. Every me_valid is accepted in its cycle.

Test Plan:
- Reset then rs1_addr=0, rs2_addr=5 -> rs1_val=0 and rs2_val is undefined-free only after a write; wb_valid=0 and instret=0 during and after reset.
- Retire me_wb_rd=3, me_wb_val=32'h12345678, rs1_addr=3 on the same edge -> rs1_val=32'h12345678 the next cycle; wb_rd=3, wb_wen=1, instret=1.
- Retire me_wb_rd=0, me_wb_val=32'hFFFFFFFF, then read x0 on both ports -> both read 0; wb_wen=0, wb_valid=1, instret incremented.
- Latch ra2=7, raise hold, retire r7=32'hCAFEF00D (BYPASS=1) -> rs2_val=32'hCAFEF00D in the same cycle; with BYPASS=0 it appears one cycle later.
- 10 back-to-back retires with alternating me_wb_en, plus 2 idle cycles -> instret=10 and only the 5 enabled registers change.
- Force instret to all-ones (INSTRET_W=8 build) and retire once -> instret=0; assert reset mid-retire -> no register write and no count.

Source files
------------

// File: rtl/yarvi_wb.sv
// Writeback stage: commits retiring results into the 32-entry integer
// register file, serves two latched-address read ports with write-first
// forwarding, registers the retired result for trace and counts retires.
module yarvi_wb #(
    parameter int XLEN      = 32,
    parameter int BYPASS    = 1,
    parameter int INSTRET_W = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 me_valid,
    input  logic                 me_wb_en,
    input  logic [4:0]           me_wb_rd,
    input  logic [XLEN-1:0]      me_wb_val,
    input  logic                 hold,
    input  logic [4:0]           rs1_addr,
    input  logic [4:0]           rs2_addr,
    output logic [XLEN-1:0]      rs1_val,
    output logic [XLEN-1:0]      rs2_val,
    output logic                 wb_valid,
    output logic                 wb_wen,
    output logic [4:0]           wb_rd,
    output logic [XLEN-1:0]      wb_val,
    output logic [INSTRET_W-1:0] instret
);

    logic [XLEN-1:0] regs [0:31];
    logic [4:0]      ra1;
    logic [4:0]      ra2;
    logic            we;

    // x0 is hardwired, so a write to it is never architecturally effective
    always_comb begin
        we = me_valid & me_wb_en & (me_wb_rd != 5'd0);
    end

    // Register array has no reset; a retire that lands while reset is held is dropped
    always_ff @(posedge clock) begin
        if (we && !reset) begin
            regs[me_wb_rd] <= me_wb_val;
        end
    end

    // Read addresses are latched unless the read stage is stalled
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ra1 <= 5'd0;
            ra2 <= 5'd0;
        end else if (!hold) begin
            ra1 <= rs1_addr;
            ra2 <= rs2_addr;
        end
    end

    // Read mux: x0 first, then the in-flight write (when bypass is built in), then the array
    always_comb begin
        rs1_val = regs[ra1];
        rs2_val = regs[ra2];
        if (ra1 == 5'd0) begin
            rs1_val = '0;
        end else if ((BYPASS != 0) && we && (me_wb_rd == ra1)) begin
            rs1_val = me_wb_val;
        end
        if (ra2 == 5'd0) begin
            rs2_val = '0;
        end else if ((BYPASS != 0) && we && (me_wb_rd == ra2)) begin
            rs2_val = me_wb_val;
        end
    end

    // Trace copy of the retiring instruction, captured every cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wb_valid <= 1'b0;
            wb_wen   <= 1'b0;
            wb_rd    <= 5'd0;
            wb_val   <= '0;
        end else begin
            wb_valid <= me_valid;
            wb_wen   <= we;
            wb_rd    <= me_wb_rd;
            wb_val   <= me_wb_val;
        end
    end

    // Retired-instruction counter, wraps freely
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instret <= '0;
        end else if (me_valid) begin
            instret <= instret + INSTRET_W'(1);
        end
    end

endmodule
